// File: rtl/iob_cache_axi_pkg.sv
// Shared AXI4 constants and FSM state encodings for the IOb cache back-end.
package iob_cache_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_DONE
    } wr_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_WAIT,
        R_ADDR,
        R_DATA,
        R_END
    } rd_state_t;

endpackage

// File: rtl/iob_cache_be_axi_wr.sv
// Write-through path: single-beat AXI writes, lane steering and
// outstanding-write counter.
module iob_cache_be_axi_wr
    import iob_cache_axi_pkg::*;
#(
    parameter int FE_ADDR_W = 24,
    parameter int FE_DATA_W = 32,
    parameter int BE_DATA_W = 32,
    parameter int OUTST_W   = 2,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_ID    = 0,
    parameter int AXI_LEN_W = 8,
    localparam int FE_NBYTES_W = $clog2(FE_DATA_W / 8),
    localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8),
    localparam int BE_NBYTES   = BE_DATA_W / 8
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic                          cke_i,
    input  logic                          write_valid_i,
    input  logic [FE_ADDR_W-FE_NBYTES_W-1:0] write_addr_i,
    input  logic [FE_DATA_W-1:0]          write_wdata_i,
    input  logic [FE_DATA_W/8-1:0]        write_wstrb_i,
    output logic                          write_ready_o,
    output logic                          wr_idle_o,
    output logic                          axi_awvalid_o,
    output logic [FE_ADDR_W-1:0]          axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]          axi_awlen_o,
    output logic [2:0]                    axi_awsize_o,
    output logic [1:0]                    axi_awburst_o,
    output logic                          axi_awlock_o,
    output logic [3:0]                    axi_awcache_o,
    output logic [2:0]                    axi_awprot_o,
    output logic [3:0]                    axi_awqos_o,
    output logic [AXI_ID_W-1:0]           axi_awid_o,
    input  logic                          axi_awready_i,
    output logic                          axi_wvalid_o,
    output logic [BE_DATA_W-1:0]          axi_wdata_o,
    output logic [BE_NBYTES-1:0]          axi_wstrb_o,
    output logic                          axi_wlast_o,
    input  logic                          axi_wready_i,
    input  logic                          axi_bvalid_i,
    output logic                          axi_bready_o
);

    wr_state_t              state;
    logic [OUTST_W:0]       cnt;
    logic                   bready_q;
    logic [FE_ADDR_W-1:0]   byte_addr;
    logic [BE_NBYTES_W-1:0] byte_off;
    logic                   b_hs;
    logic                   inc;

    assign byte_addr = {write_addr_i, {FE_NBYTES_W{1'b0}}};
    assign byte_off  = byte_addr[BE_NBYTES_W-1:0];
    assign inc       = (state == W_DONE);

    assign axi_bready_o = bready_q & cke_i;
    assign b_hs         = axi_bvalid_i & axi_bready_o;
    assign wr_idle_o    = (cnt == '0) && (state == W_IDLE);

    assign axi_awlen_o   = '0;
    assign axi_awsize_o  = 3'(BE_NBYTES_W);
    assign axi_awburst_o = AXI_BURST_INCR;
    assign axi_awlock_o  = 1'b0;
    assign axi_awcache_o = 4'b0011;
    assign axi_awprot_o  = 3'b000;
    assign axi_awqos_o   = 4'b0000;
    assign axi_awid_o    = AXI_ID_W'(AXI_ID);
    assign axi_wlast_o   = 1'b1;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state         <= W_IDLE;
            cnt           <= '0;
            bready_q      <= 1'b0;
            write_ready_o <= 1'b0;
            axi_awvalid_o <= 1'b0;
            axi_wvalid_o  <= 1'b0;
            axi_awaddr_o  <= '0;
            axi_wdata_o   <= '0;
            axi_wstrb_o   <= '0;
        end else if (cke_i) begin
            bready_q <= 1'b1;
            cnt      <= cnt + (OUTST_W+1)'(inc) - (OUTST_W+1)'(b_hs);
            case (state)
                W_IDLE: begin
                    if (write_valid_i && !cnt[OUTST_W]) begin
                        state         <= W_SEND;
                        axi_awvalid_o <= 1'b1;
                        axi_wvalid_o  <= 1'b1;
                        axi_awaddr_o  <= {byte_addr[FE_ADDR_W-1:BE_NBYTES_W],
                                          {BE_NBYTES_W{1'b0}}};
                        axi_wdata_o   <= {(BE_DATA_W/FE_DATA_W){write_wdata_i}};
                        axi_wstrb_o   <= BE_NBYTES'(write_wstrb_i) << byte_off;
                    end
                end
                W_SEND: begin
                    if (axi_awready_i) axi_awvalid_o <= 1'b0;
                    if (axi_wready_i) axi_wvalid_o <= 1'b0;
                    if ((!axi_awvalid_o || axi_awready_i) &&
                        (!axi_wvalid_o || axi_wready_i)) begin
                        state         <= W_DONE;
                        write_ready_o <= 1'b1;
                    end
                end
                W_DONE: begin
                    state         <= W_IDLE;
                    write_ready_o <= 1'b0;
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/iob_cache_be_axi_pipe.sv
// AXI4 back-end: pipelined write-through plus critical-beat line fill.
// IOB_CACHE_AXI_WRAP_EN selects WRAP bursts starting at the critical beat.
module iob_cache_be_axi_pipe
    import iob_cache_axi_pkg::*;
#(
    parameter int FE_ADDR_W     = 24,
    parameter int FE_DATA_W     = 32,
    parameter int BE_DATA_W     = 32,
    parameter int WORD_OFFSET_W = 3,
    parameter int OUTST_W       = 2,
    parameter int AXI_ID_W      = 1,
    parameter int AXI_ID        = 0,
    parameter int AXI_LEN_W     = 8,
    localparam int FE_NBYTES_W = $clog2(FE_DATA_W / 8),
    localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8),
    localparam int LINE2BE_W   = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
    localparam int RA_W        = FE_ADDR_W - BE_NBYTES_W - LINE2BE_W
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic                          cke_i,
    input  logic                          write_valid_i,
    input  logic [FE_ADDR_W-FE_NBYTES_W-1:0] write_addr_i,
    input  logic [FE_DATA_W-1:0]          write_wdata_i,
    input  logic [FE_DATA_W/8-1:0]        write_wstrb_i,
    output logic                          write_ready_o,
    input  logic                          replace_valid_i,
    input  logic [RA_W-1:0]               replace_addr_i,
    input  logic [LINE2BE_W-1:0]          replace_crit_i,
    output logic                          replace_o,
    output logic                          read_valid_o,
    output logic [LINE2BE_W-1:0]          read_addr_o,
    output logic [BE_DATA_W-1:0]          read_rdata_o,
    output logic                          wr_idle_o,
    output logic                          err_o,
    input  logic                          err_clr_i,
    output logic                          axi_awvalid_o,
    output logic [FE_ADDR_W-1:0]          axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]          axi_awlen_o,
    output logic [2:0]                    axi_awsize_o,
    output logic [1:0]                    axi_awburst_o,
    output logic                          axi_awlock_o,
    output logic [3:0]                    axi_awcache_o,
    output logic [2:0]                    axi_awprot_o,
    output logic [3:0]                    axi_awqos_o,
    output logic [AXI_ID_W-1:0]           axi_awid_o,
    input  logic                          axi_awready_i,
    output logic                          axi_wvalid_o,
    output logic [BE_DATA_W-1:0]          axi_wdata_o,
    output logic [BE_DATA_W/8-1:0]        axi_wstrb_o,
    output logic                          axi_wlast_o,
    input  logic                          axi_wready_i,
    input  logic                          axi_bvalid_i,
    input  logic [1:0]                    axi_bresp_i,
    input  logic [AXI_ID_W-1:0]           axi_bid_i,
    output logic                          axi_bready_o,
    output logic                          axi_arvalid_o,
    output logic [FE_ADDR_W-1:0]          axi_araddr_o,
    output logic [AXI_LEN_W-1:0]          axi_arlen_o,
    output logic [2:0]                    axi_arsize_o,
    output logic [1:0]                    axi_arburst_o,
    output logic                          axi_arlock_o,
    output logic [3:0]                    axi_arcache_o,
    output logic [2:0]                    axi_arprot_o,
    output logic [3:0]                    axi_arqos_o,
    output logic [AXI_ID_W-1:0]           axi_arid_o,
    input  logic                          axi_arready_i,
    input  logic                          axi_rvalid_i,
    input  logic [BE_DATA_W-1:0]          axi_rdata_i,
    input  logic [1:0]                    axi_rresp_i,
    input  logic                          axi_rlast_i,
    input  logic [AXI_ID_W-1:0]           axi_rid_i,
    output logic                          axi_rready_o
);

    rd_state_t              r_state;
    logic [LINE2BE_W-1:0]   first;
    logic [LINE2BE_W-1:0]   beat;
    logic                   r_hs;
    logic                   r_err;
    logic                   b_err;
    logic                   unused;

`ifdef IOB_CACHE_AXI_WRAP_EN
    localparam logic [1:0] AR_BURST = AXI_BURST_WRAP;
    assign first  = replace_crit_i;
    assign unused = ^{axi_bid_i, axi_rid_i};
`else
    localparam logic [1:0] AR_BURST = AXI_BURST_INCR;
    assign first  = '0;
    assign unused = ^{axi_bid_i, axi_rid_i, replace_crit_i};
`endif

    iob_cache_be_axi_wr #(
        .FE_ADDR_W (FE_ADDR_W),
        .FE_DATA_W (FE_DATA_W),
        .BE_DATA_W (BE_DATA_W),
        .OUTST_W   (OUTST_W),
        .AXI_ID_W  (AXI_ID_W),
        .AXI_ID    (AXI_ID),
        .AXI_LEN_W (AXI_LEN_W)
    ) u_wr (
        .clk_i         (clk_i),
        .arst_n_i      (arst_n_i),
        .cke_i         (cke_i),
        .write_valid_i (write_valid_i),
        .write_addr_i  (write_addr_i),
        .write_wdata_i (write_wdata_i),
        .write_wstrb_i (write_wstrb_i),
        .write_ready_o (write_ready_o),
        .wr_idle_o     (wr_idle_o),
        .axi_awvalid_o (axi_awvalid_o),
        .axi_awaddr_o  (axi_awaddr_o),
        .axi_awlen_o   (axi_awlen_o),
        .axi_awsize_o  (axi_awsize_o),
        .axi_awburst_o (axi_awburst_o),
        .axi_awlock_o  (axi_awlock_o),
        .axi_awcache_o (axi_awcache_o),
        .axi_awprot_o  (axi_awprot_o),
        .axi_awqos_o   (axi_awqos_o),
        .axi_awid_o    (axi_awid_o),
        .axi_awready_i (axi_awready_i),
        .axi_wvalid_o  (axi_wvalid_o),
        .axi_wdata_o   (axi_wdata_o),
        .axi_wstrb_o   (axi_wstrb_o),
        .axi_wlast_o   (axi_wlast_o),
        .axi_wready_i  (axi_wready_i),
        .axi_bvalid_i  (axi_bvalid_i),
        .axi_bready_o  (axi_bready_o)
    );

    assign axi_arlen_o   = AXI_LEN_W'((1 << LINE2BE_W) - 1);
    assign axi_arsize_o  = 3'(BE_NBYTES_W);
    assign axi_arburst_o = AR_BURST;
    assign axi_arlock_o  = 1'b0;
    assign axi_arcache_o = 4'b0011;
    assign axi_arprot_o  = 3'b000;
    assign axi_arqos_o   = 4'b0000;
    assign axi_arid_o    = AXI_ID_W'(AXI_ID);

    assign replace_o    = (r_state != R_IDLE);
    assign axi_rready_o = (r_state == R_DATA) & cke_i;
    assign r_hs         = axi_rvalid_i & axi_rready_o;
    assign r_err        = r_hs & (axi_rresp_i != AXI_RESP_OKAY);
    assign b_err        = axi_bvalid_i & axi_bready_o &
                          (axi_bresp_i != AXI_RESP_OKAY);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state       <= R_IDLE;
            axi_arvalid_o <= 1'b0;
            axi_araddr_o  <= '0;
            beat          <= '0;
            read_valid_o  <= 1'b0;
            read_addr_o   <= '0;
            read_rdata_o  <= '0;
            err_o         <= 1'b0;
        end else if (cke_i) begin
            read_valid_o <= r_hs;
            if (r_hs) begin
                read_rdata_o <= axi_rdata_i;
                read_addr_o  <= beat;
                beat         <= beat + 1'b1;
            end
            // a new error outranks a clear in the same cycle
            if (r_err || b_err) err_o <= 1'b1;
            else if (err_clr_i) err_o <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (replace_valid_i) begin
                        r_state      <= R_WAIT;
                        axi_araddr_o <= {replace_addr_i, first,
                                         {BE_NBYTES_W{1'b0}}};
                        beat         <= first;
                    end
                end
                R_WAIT: begin
                    if (wr_idle_o) begin
                        r_state       <= R_ADDR;
                        axi_arvalid_o <= 1'b1;
                    end
                end
                R_ADDR: begin
                    if (axi_arready_i) begin
                        r_state       <= R_DATA;
                        axi_arvalid_o <= 1'b0;
                    end
                end
                R_DATA: if (r_hs && axi_rlast_i) r_state <= R_END;
                R_END:  r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
